// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory-controller port among NUM_REQ requesters.
// One transaction in flight at a time; a watchdog aborts stalled transfers with an error.
module mem_port_arbiter #(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 64,
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   localparam int unsigned GRANT_W       = $clog2(NUM_REQ)
) (
   input  logic                             sys_clk,
   input  logic                             sys_rst,
   input  logic [NUM_REQ-1:0]               req_valid,
   input  logic [NUM_REQ-1:0]               req_write,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
   output logic [NUM_REQ-1:0]               req_ready,
   output logic [DATA_WIDTH-1:0]            req_rdata,
   output logic                             req_err,
   output logic                             mem_valid,
   output logic                             mem_write,
   output logic [ADDR_WIDTH-1:0]            mem_addr,
   output logic [DATA_WIDTH-1:0]            mem_wdata,
   input  logic [DATA_WIDTH-1:0]            mem_rdata,
   input  logic                             mem_ready,
   output logic [GRANT_W-1:0]               grant_id,
   output logic                             busy
);

   localparam int unsigned CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
   localparam logic [CNT_W-1:0] TO_LAST_C = CNT_W'(TO_LAST);

   typedef enum logic [1:0] {StIdle, StBusy, StResp} state_t;

   state_t                state_q;
   logic [GRANT_W-1:0]    last_q;
   logic [CNT_W-1:0]      cnt_q;

   logic [GRANT_W-1:0]    pick;
   logic                  sel_write;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;

   // Search last+1, last+2, ... so the most recent winner has lowest priority.
   always_comb begin
      logic        found;
      int unsigned idx;
      found = 1'b0;
      pick  = '0;
      idx   = 0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         idx = (32'(last_q) + k) % NUM_REQ;
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            pick  = GRANT_W'(idx);
         end
      end
   end

   always_comb begin
      sel_write = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (GRANT_W'(i) == pick) begin
            sel_write = req_write[i];
            sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q   <= StIdle;
         last_q    <= GRANT_W'(NUM_REQ - 1);
         cnt_q     <= '0;
         req_ready <= '0;
         req_rdata <= '0;
         req_err   <= 1'b0;
         mem_valid <= 1'b0;
         mem_write <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         grant_id  <= '0;
         busy      <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (|req_valid) begin
                  grant_id  <= pick;
                  mem_addr  <= sel_addr;
                  mem_wdata <= sel_wdata;
                  mem_write <= sel_write;
                  mem_valid <= 1'b1;
                  busy      <= 1'b1;
                  cnt_q     <= '0;
                  state_q   <= StBusy;
               end
            end
            StBusy: begin
               // A completion on the timeout cycle still counts as a normal completion.
               if (mem_ready) begin
                  req_rdata <= mem_write ? '0 : mem_rdata;
                  mem_valid <= 1'b0;
                  req_ready <= NUM_REQ'(1) << grant_id;
                  req_err   <= 1'b0;
                  state_q   <= StResp;
               end else if (TIMEOUT_CYCLES != 0 && cnt_q == TO_LAST_C) begin
                  req_rdata <= '0;
                  mem_valid <= 1'b0;
                  req_ready <= NUM_REQ'(1) << grant_id;
                  req_err   <= 1'b1;
                  state_q   <= StResp;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StResp: begin
               req_ready <= '0;
               req_err   <= 1'b0;
               busy      <= 1'b0;
               last_q    <= grant_id;
               cnt_q     <= '0;
               state_q   <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: latency, round-robin order, write hold,
// timeout abort, timeout/ready race and asynchronous reset.
module tb_mem_port_arbiter;

   localparam int unsigned NR = 4;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 64;

   logic              sys_clk = 1'b0;
   logic              sys_rst = 1'b1;
   logic [NR-1:0]     req_valid = '0;
   logic [NR-1:0]     req_write = '0;
   logic [NR*AW-1:0]  req_addr = '0;
   logic [NR*DW-1:0]  req_wdata = '0;
   logic [NR-1:0]     req_ready;
   logic [DW-1:0]     req_rdata;
   logic              req_err;
   logic              mem_valid;
   logic              mem_write;
   logic [AW-1:0]     mem_addr;
   logic [DW-1:0]     mem_wdata;
   logic [DW-1:0]     mem_rdata = '0;
   logic              mem_ready = 1'b0;
   logic [1:0]        grant_id;
   logic              busy;

   int checks = 0;
   int errors = 0;

   mem_port_arbiter #(
      .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)
   ) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_ready(req_ready), .req_rdata(req_rdata),
      .req_err(req_err), .mem_valid(mem_valid), .mem_write(mem_write),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ready(mem_ready), .grant_id(grant_id), .busy(busy)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".req_ready"}, 64'(req_ready), 64'h0);
      chk({tag, ".req_rdata"}, req_rdata, 64'h0);
      chk({tag, ".req_err"}, 64'(req_err), 64'h0);
      chk({tag, ".mem_valid"}, 64'(mem_valid), 64'h0);
      chk({tag, ".mem_write"}, 64'(mem_write), 64'h0);
      chk({tag, ".mem_addr"}, 64'(mem_addr), 64'h0);
      chk({tag, ".mem_wdata"}, mem_wdata, 64'h0);
      chk({tag, ".grant_id"}, 64'(grant_id), 64'h0);
      chk({tag, ".busy"}, 64'(busy), 64'h0);
   endtask

   task automatic do_reset();
      sys_rst = 1'b1;
      tick();
      tick();
      sys_rst = 1'b0;
      tick();
   endtask

   initial begin
      int exp_g;
      for (int i = 0; i < NR; i++) begin
         req_addr[i*AW +: AW]  = 32'h1000 + 32'(i) * 32'h10;
         req_wdata[i*DW +: DW] = 64'hA000 + 64'(i);
      end

      // Reset state
      do_reset();
      chk_all_zero("reset");

      // Single read from requester 0
      req_addr[0 +: AW] = 32'h100;
      req_valid = 4'b0001;
      tick();
      chk("rd.mem_valid", 64'(mem_valid), 64'h1);
      chk("rd.mem_addr", 64'(mem_addr), 64'h100);
      chk("rd.mem_write", 64'(mem_write), 64'h0);
      chk("rd.busy", 64'(busy), 64'h1);
      chk("rd.req_ready_busy", 64'(req_ready), 64'h0);
      mem_ready = 1'b1;
      mem_rdata = 64'hDEAD;
      tick();
      chk("rd.req_ready", 64'(req_ready), 64'h1);
      chk("rd.req_rdata", req_rdata, 64'hDEAD);
      chk("rd.req_err", 64'(req_err), 64'h0);
      chk("rd.mem_valid_drop", 64'(mem_valid), 64'h0);
      req_valid = '0;
      mem_ready = 1'b0;
      mem_rdata = '0;
      tick();
      chk("rd.idle_ready", 64'(req_ready), 64'h0);
      chk("rd.idle_busy", 64'(busy), 64'h0);
      chk("rd.rdata_hold", req_rdata, 64'hDEAD);

      // Round robin, all requesters valid, mem_ready always high
      do_reset();
      req_addr[0 +: AW] = 32'h1000;
      req_valid = 4'b1111;
      mem_ready = 1'b1;
      for (int n = 0; n < 5; n++) begin
         exp_g = n % 4;
         tick();
         chk($sformatf("rr%0d.grant", n), 64'(grant_id), 64'(exp_g));
         chk($sformatf("rr%0d.mem_addr", n), 64'(mem_addr), 64'h1000 + 64'(exp_g) * 64'h10);
         chk($sformatf("rr%0d.mem_valid", n), 64'(mem_valid), 64'h1);
         tick();
         chk($sformatf("rr%0d.req_ready", n), 64'(req_ready), 64'(4'b0001 << exp_g));
         tick();
         chk($sformatf("rr%0d.gap", n), 64'(req_ready), 64'h0);
         if (n == 4) begin
            req_valid = '0;
            mem_ready = 1'b0;
         end
      end

      // Write from requester 2 with mem_ready late; last winner was 0
      req_addr[2*AW +: AW]  = 32'h40;
      req_wdata[2*DW +: DW] = 64'h1234;
      req_write = 4'b0100;
      req_valid = 4'b0100;
      for (int c = 1; c <= 6; c++) begin
         tick();
         if (c == 6) begin
            mem_ready = 1'b1;
            mem_rdata = 64'hBEEF;
         end
         chk($sformatf("wr.c%0d.mem_valid", c), 64'(mem_valid), 64'h1);
         chk($sformatf("wr.c%0d.mem_addr", c), 64'(mem_addr), 64'h40);
         chk($sformatf("wr.c%0d.mem_wdata", c), mem_wdata, 64'h1234);
         chk($sformatf("wr.c%0d.mem_write", c), 64'(mem_write), 64'h1);
         chk($sformatf("wr.c%0d.req_ready", c), 64'(req_ready), 64'h0);
      end
      tick();
      chk("wr.req_ready", 64'(req_ready), 64'h4);
      chk("wr.req_rdata", req_rdata, 64'h0);
      chk("wr.req_err", 64'(req_err), 64'h0);
      req_valid = '0;
      req_write = '0;
      mem_ready = 1'b0;
      tick();

      // mem_ready on the timeout cycle: requester 3 read completes normally
      req_valid = 4'b1000;
      for (int c = 1; c <= 8; c++) begin
         tick();
         chk($sformatf("race.c%0d.mem_valid", c), 64'(mem_valid), 64'h1);
         if (c == 8) begin
            mem_ready = 1'b1;
            mem_rdata = 64'h55;
         end
      end
      tick();
      chk("race.req_ready", 64'(req_ready), 64'h8);
      chk("race.req_err", 64'(req_err), 64'h0);
      chk("race.req_rdata", req_rdata, 64'h55);
      req_valid = '0;
      mem_ready = 1'b0;
      mem_rdata = 64'h77;
      tick();

      // Timeout: requester 1 read, controller never answers
      req_valid = 4'b0010;
      for (int c = 1; c <= 8; c++) begin
         tick();
         chk($sformatf("to.c%0d.mem_valid", c), 64'(mem_valid), 64'h1);
         chk($sformatf("to.c%0d.req_ready", c), 64'(req_ready), 64'h0);
      end
      tick();
      chk("to.mem_valid_drop", 64'(mem_valid), 64'h0);
      chk("to.req_ready", 64'(req_ready), 64'h2);
      chk("to.req_err", 64'(req_err), 64'h1);
      chk("to.req_rdata", req_rdata, 64'h0);
      req_valid = '0;
      tick();
      chk("to.idle_err", 64'(req_err), 64'h0);
      chk("to.idle_ready", 64'(req_ready), 64'h0);

      // Next grant after the timeout proceeds normally
      req_valid = 4'b0001;
      tick();
      chk("post.grant", 64'(grant_id), 64'h0);
      mem_ready = 1'b1;
      mem_rdata = 64'h99;
      tick();
      chk("post.req_ready", 64'(req_ready), 64'h1);
      chk("post.req_err", 64'(req_err), 64'h0);
      chk("post.req_rdata", req_rdata, 64'h99);
      req_valid = '0;
      mem_ready = 1'b0;
      tick();

      // Asynchronous reset in the middle of a transfer from requester 2
      req_valid = 4'b0100;
      tick();
      tick();
      chk("arst.pre_busy", 64'(busy), 64'h1);
      chk("arst.pre_grant", 64'(grant_id), 64'h2);
      #2;
      sys_rst = 1'b1;
      #1;
      chk_all_zero("arst");
      req_valid = 4'b0101;
      #2;
      sys_rst = 1'b0;
      tick();
      chk("arst.grant", 64'(grant_id), 64'h0);
      chk("arst.mem_valid", 64'(mem_valid), 64'h1);
      chk("arst.no_stale", 64'(req_ready), 64'h0);
      req_valid = '0;
      mem_ready = 1'b1;
      mem_rdata = 64'h11;
      tick();
      chk("arst.req_ready", 64'(req_ready), 64'h1);
      mem_ready = 1'b0;
      tick();
      chk("arst.idle", 64'(busy), 64'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
